// File: rtl/program_loader_if.sv
// rtl/program_loader_if.sv - instruction stream handshake between host and program loader

interface program_loader_if;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] in_op;
  logic [1:0] in_rs;
  logic [1:0] in_rt;
  logic [1:0] in_rd;
  logic [7:0] in_imm;
  logic       in_last;

  modport master (
    output in_valid, in_op, in_rs, in_rt, in_rd, in_imm, in_last,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_op, in_rs, in_rt, in_rd, in_imm, in_last,
    output in_ready
  );
endinterface

// File: rtl/program_loader.sv
// rtl/program_loader.sv - encodes streamed instructions into an 8-word store and launches the core

module program_loader #(
  parameter logic [7:0] OP_ADD  = 8'h20,
  parameter logic [7:0] OP_SUB  = 8'h10,
  parameter logic [7:0] OP_SLA  = 8'h08,
  parameter logic [7:0] OP_SRA  = 8'h04,
  parameter logic [7:0] OP_ST   = 8'h40,
  parameter logic [7:0] OP_LD   = 8'h80,
  parameter int         START_W = 1
) (
  input  logic                 CLK,
  input  logic                 RST,
  program_loader_if.slave      bus,
  input  logic                 reload,
  output logic [31:0]          IM0,
  output logic [31:0]          IM1,
  output logic [31:0]          IM2,
  output logic [31:0]          IM3,
  output logic [31:0]          IM4,
  output logic [31:0]          IM5,
  output logic [31:0]          IM6,
  output logic [31:0]          IM7,
  output logic [3:0]           count,
  output logic                 cpu_rst,
  output logic                 err
);

  localparam int SW = (START_W > 1) ? $clog2(START_W) : 1;

  typedef enum logic [1:0] {LOAD = 2'd0, START = 2'd1, RUN = 2'd2} state_t;

  state_t        state, state_nxt;
  logic [31:0]   im [8];
  logic [31:0]   enc;
  logic          legal;
  logic          xfer;
  logic [SW-1:0] start_cnt;

  assign xfer = bus.in_valid && (state == LOAD);

  assign IM0 = im[0];
  assign IM1 = im[1];
  assign IM2 = im[2];
  assign IM3 = im[3];
  assign IM4 = im[4];
  assign IM5 = im[5];
  assign IM6 = im[6];
  assign IM7 = im[7];

  // Build the 32-bit control-unit word from the incoming fields; ops 6/7 are illegal
  always_comb begin
    enc   = 32'h0;
    legal = 1'b1;
    case (bus.in_op)
      3'd0: enc = {OP_ADD, 6'd0, bus.in_rs, 6'd0, bus.in_rt, 6'd0, bus.in_rd};
      3'd1: enc = {OP_SUB, 6'd0, bus.in_rs, 6'd0, bus.in_rt, 6'd0, bus.in_rd};
      3'd2: enc = {OP_SLA, 6'd0, bus.in_rs, bus.in_imm, 6'd0, bus.in_rd};
      3'd3: enc = {OP_SRA, 6'd0, bus.in_rs, bus.in_imm, 6'd0, bus.in_rd};
      3'd4: enc = {OP_ST, bus.in_imm, 6'd0, bus.in_rt, 8'd0};
      3'd5: enc = {OP_LD, bus.in_imm, 6'd0, bus.in_rt, 8'd0};
      default: legal = 1'b0;
    endcase
  end

  // State register
  always_ff @(posedge CLK) begin
    if (RST) state <= LOAD;
    else     state <= state_nxt;
  end

  // Next-state: leave LOAD on in_last or when the 8th legal word lands
  always_comb begin
    state_nxt = state;
    case (state)
      LOAD: begin
        if (xfer && (bus.in_last || (legal && count == 4'd7))) state_nxt = START;
      end
      START: begin
        if (start_cnt == SW'(START_W - 1)) state_nxt = RUN;
      end
      RUN: begin
        if (reload) state_nxt = LOAD;
      end
      default: state_nxt = LOAD;
    endcase
  end

  // Outputs depend on state only, so in_ready has no path from in_valid
  always_comb begin
    bus.in_ready = 1'b0;
    cpu_rst      = 1'b0;
    case (state)
      LOAD:    bus.in_ready = 1'b1;
      START:   cpu_rst      = 1'b1;
      default: ;
    endcase
  end

  // Instruction store, word count, sticky error and START pulse timer
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < 8; i++) im[i] <= 32'h0;
      count     <= 4'd0;
      err       <= 1'b0;
      start_cnt <= '0;
    end else begin
      start_cnt <= (state == START) ? start_cnt + 1'b1 : '0;
      if (xfer) begin
        if (legal) begin
          im[count[2:0]] <= enc;
          count          <= count + 4'd1;
        end else begin
          err <= 1'b1;
        end
      end
      if (state == RUN && reload) begin
        for (int i = 0; i < 8; i++) im[i] <= 32'h0;
        count <= 4'd0;
      end
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// tb/tb_program_loader.sv - directed self-checking bench for program_loader

module tb_program_loader;
  logic        CLK = 1'b0;
  logic        RST;
  logic        reload;
  logic [31:0] IM0, IM1, IM2, IM3, IM4, IM5, IM6, IM7;
  logic [3:0]  count;
  logic        cpu_rst;
  logic        err;

  int vectors = 0;
  int miscompares = 0;

  program_loader_if bus ();

  program_loader dut (
    .CLK(CLK), .RST(RST), .bus(bus), .reload(reload),
    .IM0(IM0), .IM1(IM1), .IM2(IM2), .IM3(IM3),
    .IM4(IM4), .IM5(IM5), .IM6(IM6), .IM7(IM7),
    .count(count), .cpu_rst(cpu_rst), .err(err)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic send(input logic [2:0] op, input logic [1:0] rs, input logic [1:0] rt,
                      input logic [1:0] rd, input logic [7:0] imm, input logic last);
    bus.in_op    = op;
    bus.in_rs    = rs;
    bus.in_rt    = rt;
    bus.in_rd    = rd;
    bus.in_imm   = imm;
    bus.in_last  = last;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic do_reload();
    reload = 1'b1;
    tick();
    reload = 1'b0;
  endtask

  function automatic logic [31:0] im_at(input int i);
    case (i)
      0: return IM0; 1: return IM1; 2: return IM2; 3: return IM3;
      4: return IM4; 5: return IM5; 6: return IM6; default: return IM7;
    endcase
  endfunction

  initial begin
    RST = 1'b1; reload = 1'b0;
    bus.in_valid = 1'b0; bus.in_op = 3'd0; bus.in_rs = 2'd0; bus.in_rt = 2'd0;
    bus.in_rd = 2'd0; bus.in_imm = 8'd0; bus.in_last = 1'b0;
    tick(); tick();
    RST = 1'b0;

    check("rst_im0", IM0, 32'h0);
    check("rst_count", {28'h0, count}, 32'd0);
    check("rst_cpu_rst", {31'h0, cpu_rst}, 32'd0);
    check("rst_err", {31'h0, err}, 32'd0);
    check("rst_ready", {31'h0, bus.in_ready}, 32'd1);

    // T1: single add, last
    send(3'd0, 2'd1, 2'd2, 2'd3, 8'd0, 1'b1);
    check("t1_im0", IM0, 32'h20010203);
    check("t1_count", {28'h0, count}, 32'd1);
    check("t1_pulse_hi", {31'h0, cpu_rst}, 32'd1);
    check("t1_ready_start", {31'h0, bus.in_ready}, 32'd0);
    tick();
    check("t1_pulse_lo", {31'h0, cpu_rst}, 32'd0);
    check("t1_ready_run", {31'h0, bus.in_ready}, 32'd0);
    for (int i = 1; i < 8; i++) check($sformatf("t1_im%0d_zero", i), im_at(i), 32'h0);
    do_reload();
    check("reload_im0", IM0, 32'h0);
    check("reload_count", {28'h0, count}, 32'd0);
    check("reload_ready", {31'h0, bus.in_ready}, 32'd1);

    // T2: shifts
    send(3'd2, 2'd2, 2'd0, 2'd0, 8'd4, 1'b0);
    check("t2_ready_mid", {31'h0, bus.in_ready}, 32'd1);
    send(3'd3, 2'd3, 2'd0, 2'd1, 8'd1, 1'b1);
    check("t2_im0", IM0, 32'h08020400);
    check("t2_im1", IM1, 32'h04030101);
    tick();
    do_reload();

    // T3: store / load
    send(3'd4, 2'd0, 2'd1, 2'd0, 8'd5, 1'b0);
    send(3'd5, 2'd0, 2'd2, 2'd0, 8'd3, 1'b1);
    check("t3_im0", IM0, 32'h40050100);
    check("t3_im1", IM1, 32'h80030200);
    check("t3_count", {28'h0, count}, 32'd2);
    tick();
    do_reload();

    // T4: 8 legal ops fill the store; 9th refused
    for (int i = 0; i < 8; i++) send(3'd0, 2'd0, 2'd0, 2'(i), 8'd0, 1'b0);
    check("t4_count", {28'h0, count}, 32'd8);
    check("t4_ready", {31'h0, bus.in_ready}, 32'd0);
    check("t4_start", {31'h0, cpu_rst}, 32'd1);
    send(3'd1, 2'd3, 2'd3, 2'd3, 8'd0, 1'b1);
    check("t4_count_9th", {28'h0, count}, 32'd8);
    check("t4_im0", IM0, 32'h20000000);
    check("t4_im7", IM7, 32'h20000003);
    check("t4_im4", IM4, 32'h20000000);
    check("t4_err", {31'h0, err}, 32'd0);
    do_reload();

    // T5: illegal op mid-program
    send(3'd0, 2'd0, 2'd0, 2'd1, 8'd0, 1'b0);
    send(3'd6, 2'd1, 2'd1, 2'd1, 8'hFF, 1'b0);
    check("t5_err", {31'h0, err}, 32'd1);
    check("t5_count", {28'h0, count}, 32'd1);
    check("t5_ready", {31'h0, bus.in_ready}, 32'd1);
    send(3'd1, 2'd0, 2'd0, 2'd2, 8'd0, 1'b1);
    check("t5_im1", IM1, 32'h10000002);
    check("t5_im2", IM2, 32'h0);
    tick();
    do_reload();
    check("t5_err_kept", {31'h0, err}, 32'd1);

    // T6: RST mid-LOAD with count=3
    for (int i = 0; i < 3; i++) send(3'd0, 2'd1, 2'd1, 2'd1, 8'd0, 1'b0);
    check("t6_count3", {28'h0, count}, 32'd3);
    RST = 1'b1;
    reload = 1'b1;
    tick();
    RST = 1'b0;
    reload = 1'b0;
    check("t6_count", {28'h0, count}, 32'd0);
    check("t6_im0", IM0, 32'h0);
    check("t6_im2", IM2, 32'h0);
    check("t6_err", {31'h0, err}, 32'd0);
    check("t6_ready", {31'h0, bus.in_ready}, 32'd1);

    // Illegal op with last at count=0 still launches an all-zero program
    send(3'd7, 2'd0, 2'd0, 2'd0, 8'd0, 1'b1);
    check("ill_last_start", {31'h0, cpu_rst}, 32'd1);
    check("ill_last_count", {28'h0, count}, 32'd0);
    check("ill_last_err", {31'h0, err}, 32'd1);
    check("ill_last_im0", IM0, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
